// File: rtl/pattern_rom_arbiter.sv
// ============================================================================
// Module   : pattern_rom_arbiter
// Purpose  : Round-robin arbiter sharing one synchronous pattern ROM
//            (1-cycle read latency) among NUM_CH per-voice pattern
//            sequencers. One read can be issued per cycle. Each read word
//            is routed back to the channel that issued it with a one-hot
//            acknowledge pulse.
// Ports    : i_clk       - system clock, rising edge
//            i_rst_n     - asynchronous active-low reset
//            i_req       - per-channel read request (held until ack)
//            i_addr      - per-channel address, channel c at [c*AW +: AW]
//            o_ack       - one-hot pulse, o_rdata valid for that channel
//            o_rdata     - read data shared by all channels
//            o_rom_addr  - registered ROM address
//            i_rom_data  - ROM data, valid the cycle after o_rom_addr
//            o_busy      - a read is in flight in either pipeline stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_rom_arbiter #(
    parameter int NUM_CH = 4,
    parameter int AW     = 8,
    parameter int DW     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_CH-1:0]    i_req,
    input  logic [NUM_CH*AW-1:0] i_addr,
    output logic [NUM_CH-1:0]    o_ack,
    output logic [DW-1:0]        o_rdata,
    output logic [AW-1:0]        o_rom_addr,
    input  logic [DW-1:0]        i_rom_data,
    output logic                 o_busy
);

    localparam int            PW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PW:0]   C_NUM_CH = (PW+1)'(NUM_CH);

    // Pipeline state: s1 = address presented to ROM, s2 = ROM data returning
    logic [PW-1:0]     rr_ptr_q,   rr_ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [PW-1:0]     s1_id_q,    s1_id_d;
    logic              s2_valid_q;
    logic [PW-1:0]     s2_id_q;
    logic [AW-1:0]     rom_addr_q, rom_addr_d;

    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_rot;
    logic              w_any;
    logic [PW-1:0]     w_off;
    logic [PW:0]       w_sum;
    logic [PW:0]       w_win_ext;
    logic [PW-1:0]     w_win_id;
    logic [PW:0]       w_nxt_ext;
    logic [AW-1:0]     w_win_addr;

    // A channel already occupying s1 or s2 is masked so a held request is
    // never granted twice for the same read.
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_elig
            assign w_elig[g] = i_req[g]
                             & ~(s1_valid_q & (s1_id_q == PW'(g)))
                             & ~(s2_valid_q & (s2_id_q == PW'(g)));
        end
    endgenerate

    // Rotate eligibility so bit 0 corresponds to rr_ptr, then pick the
    // lowest set bit; the winner is rr_ptr plus that offset, mod NUM_CH.
    assign w_rot = NUM_CH'({w_elig, w_elig} >> rr_ptr_q);
    assign w_any = |w_rot;

    always_comb begin
        w_off = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PW'(i);
            end
        end
    end

    assign w_sum     = {1'b0, rr_ptr_q} + {1'b0, w_off};
    assign w_win_ext = (w_sum >= C_NUM_CH) ? (w_sum - C_NUM_CH) : w_sum;
    assign w_win_id  = w_win_ext[PW-1:0];
    assign w_nxt_ext = {1'b0, w_win_id} + {{PW{1'b0}}, 1'b1};

    always_comb begin
        w_win_addr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_win_id == PW'(c)) begin
                w_win_addr = i_addr[c*AW +: AW];
            end
        end
    end

    // Next-state: address and pointer only advance on a grant
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_id_d    = s1_id_q;
        rom_addr_d = rom_addr_q;
        s1_valid_d = w_any;
        if (w_any) begin
            s1_id_d    = w_win_id;
            rom_addr_d = w_win_addr;
            rr_ptr_d   = (w_nxt_ext == C_NUM_CH) ? '0 : w_nxt_ext[PW-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            rom_addr_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            rom_addr_q <= rom_addr_d;
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
        end
    end

    // Ack is a pure decode of registered s2 state, so it is glitch-free
    // and at most one-hot by construction.
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ack
            assign o_ack[g] = s2_valid_q & (s2_id_q == PW'(g));
        end
    endgenerate

    assign o_rdata    = i_rom_data;
    assign o_rom_addr = rom_addr_q;
    assign o_busy     = s1_valid_q | s2_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_rom_arbiter.sv
// ============================================================================
// Module   : tb_pattern_rom_arbiter
// Purpose  : Self-checking bench for pattern_rom_arbiter with a behavioural
//            ROM holding memory[a] = {a, ~a}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pattern_rom_arbiter;

    localparam int NUM_CH = 4;
    localparam int AW     = 8;
    localparam int DW     = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    req;
    logic [NUM_CH*AW-1:0] addr;
    logic [NUM_CH-1:0]    ack;
    logic [DW-1:0]        rdata;
    logic [AW-1:0]        rom_addr;
    logic [DW-1:0]        rom_data;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // One-cycle-latency ROM model
    always @(posedge clk) rom_data <= {rom_addr, ~rom_addr};

    pattern_rom_arbiter #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_addr     (addr),
        .o_ack      (ack),
        .o_rdata    (rdata),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        addr[c*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        addr  = '0;
        step();
        step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr: got %h expected 00", rom_addr); end
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        req = 4'b0010;
        set_addr(1, 8'h12);
        step();
        checks++; if (rom_addr !== 8'h12) begin errors++; $display("FAIL single_rom_addr: got %h expected 12", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1: got %b expected 1", busy); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_early_ack: got %b expected 0000", ack); end
        step();
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b expected 0010", ack); end
        checks++; if (rdata !== 16'h12ED) begin errors++; $display("FAIL single_rdata: got %h expected 12ed", rdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy2: got %b expected 1", busy); end
        req = '0;
        step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_end: got %b expected 0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_all_channels();
        logic [AW-1:0] a;
        do_reset();
        for (int c = 0; c < NUM_CH; c++) set_addr(c, 8'((c+1) * 16));
        req = 4'b1111;
        step();
        checks++; if (rom_addr !== 8'h10) begin errors++; $display("FAIL all_first_addr: got %h expected 10", rom_addr); end
        for (int k = 0; k < NUM_CH; k++) begin
            step();
            a = 8'((k+1) * 16);
            checks++; if (ack !== 4'(1 << k)) begin errors++; $display("FAIL all_ack%0d: got %b expected %b", k, ack, 4'(1 << k)); end
            checks++; if (rdata !== {a, ~a}) begin errors++; $display("FAIL all_rdata%0d: got %h expected %h", k, rdata, {a, ~a}); end
            if (k < NUM_CH-1) begin
                checks++; if (rom_addr !== 8'((k+2) * 16)) begin errors++; $display("FAIL all_addr%0d: got %h expected %h", k+1, rom_addr, 8'((k+2) * 16)); end
            end
            req[k] = 1'b0;
        end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL all_drain_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        int n;
        a = 8'h40;
        set_addr(2, a);
        req = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (ack === 4'b0000 && n < 8);
            checks++; if (n != ((k == 0) ? 2 : 3)) begin errors++; $display("FAIL b2b_spacing%0d: got %0d cycles expected %0d", k, n, (k == 0) ? 2 : 3); end
            checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL b2b_ack%0d: got %b expected 0100", k, ack); end
            checks++; if (rdata !== {a, ~a}) begin errors++; $display("FAIL b2b_rdata%0d: got %h expected %h", k, rdata, {a, ~a}); end
            a = a + 8'd1;
            set_addr(2, a);
        end
        req = '0;
        step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL b2b_extra_ack: got %b expected 0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", busy); end
    endtask

    task automatic test_fairness();
        do_reset();
        set_addr(0, 8'hA0);
        set_addr(3, 8'hD3);
        req = 4'b1001;
        step();
        checks++; if (rom_addr !== 8'hA0) begin errors++; $display("FAIL fair_grant0: got %h expected a0", rom_addr); end
        step();
        checks++; if (rom_addr !== 8'hD3) begin errors++; $display("FAIL fair_grant3: got %h expected d3", rom_addr); end
        checks++; if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL fair_rr_wrap: got %0d expected 0", dut.rr_ptr_q); end
        checks++; if (ack !== 4'b0001 || rdata !== 16'hA05F) begin errors++; $display("FAIL fair_ack0: got %b/%h expected 0001/a05f", ack, rdata); end
        set_addr(0, 8'hA1);
        step();
        checks++; if (ack !== 4'b1000 || rdata !== 16'hD32C) begin errors++; $display("FAIL fair_ack3: got %b/%h expected 1000/d32c", ack, rdata); end
        req[3] = 1'b0;
        step();
        checks++; if (rom_addr !== 8'hA1) begin errors++; $display("FAIL fair_regrant0: got %h expected a1", rom_addr); end
        step();
        checks++; if (ack !== 4'b0001 || rdata !== 16'hA15E) begin errors++; $display("FAIL fair_ack0b: got %b/%h expected 0001/a15e", ack, rdata); end
        req = '0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_addr(1, 8'h55);
        req = 4'b0010;
        step();
        checks++; if (rom_addr !== 8'h55) begin errors++; $display("FAIL rst_grant: got %h expected 55", rom_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL rst_rom_addr: got %h expected 00", rom_addr); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack%0d: got %b expected 0000", i, ack); end
        end
        rst_n = 1'b1;
        set_addr(1, 8'h66);
        step();
        checks++; if (rom_addr !== 8'h66) begin errors++; $display("FAIL rst_regrant: got %h expected 66", rom_addr); end
        step();
        checks++; if (ack !== 4'b0010 || rdata !== 16'h6699) begin errors++; $display("FAIL rst_reack: got %b/%h expected 0010/6699", ack, rdata); end
        req = '0;
        step();
        step();
    endtask

    task automatic test_random();
        int            st    [NUM_CH];
        int            wt    [NUM_CH];
        int            drain [NUM_CH];
        logic [AW-1:0] cur   [NUM_CH];
        int            acks;
        acks = 0;
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            st[c] = 0; wt[c] = 0; drain[c] = 0; cur[c] = '0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            step();
            checks++; if ($countones(ack) > 1) begin errors++; $display("FAIL rnd_onehot: got %b at cycle %0d", ack, cyc); end
            for (int c = 0; c < NUM_CH; c++) begin
                if (st[c] == 1) wt[c]++;
                if (ack[c] === 1'b1) begin
                    acks++;
                    checks++;
                    if (st[c] == 0) begin
                        errors++; $display("FAIL rnd_spurious_ack: ch%0d got ack with no request", c);
                    end else if (rdata !== {cur[c], ~cur[c]}) begin
                        errors++; $display("FAIL rnd_rdata: ch%0d got %h expected %h", c, rdata, {cur[c], ~cur[c]});
                    end
                    if (st[c] == 1) begin
                        checks++; if (wt[c] > 7) begin errors++; $display("FAIL rnd_latency: ch%0d got %0d cycles expected <= 7", c, wt[c]); end
                    end
                    st[c]  = 0;
                    req[c] = 1'b0;
                end
                if (st[c] == 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        cur[c] = 8'($urandom);
                        set_addr(c, cur[c]);
                        req[c] = 1'b1;
                        st[c]  = 1;
                        wt[c]  = 0;
                    end
                end else if (st[c] == 1) begin
                    if (wt[c] > 8) begin
                        checks++; errors++;
                        $display("FAIL rnd_starved: ch%0d got no ack after %0d cycles expected <= 7", c, wt[c]);
                        req[c] = 1'b0; st[c] = 2; drain[c] = 3;
                    end else if ($urandom_range(0, 15) == 0) begin
                        req[c] = 1'b0; st[c] = 2; drain[c] = 3;
                    end
                end else begin
                    drain[c]--;
                    if (drain[c] == 0) st[c] = 0;
                end
            end
        end
        checks++; if (acks < 1000) begin errors++; $display("FAIL rnd_activity: got %0d acks expected >= 1000", acks); end
        req = '0;
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_back_to_back();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
